eth_rst_seq: RTL

ETH_RST_SEQ -- requirements
Module: eth_rst_seq

---
 rtl/eth_rst_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/eth_rst_seq.sv
// Ethernet reset sequencer.
// Waits for a stable clock-generator lock, then holds the PHY in hardware
// reset for a fixed time and lets it settle before the MAC is released.
// Lock loss at any point past IDLE restarts the whole sequence. A software
// request in RUN re-runs only the PHY reset and settle phases.
module eth_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned PHY_RST_CYCLES     = 1250000,
  parameter int unsigned PHY_WAIT_CYCLES    = 6250,
  parameter int unsigned CNT_W              = 24
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clk_locked,
  input  logic       sw_rst_req,
  output logic       phy_rst_n,
  output logic       eth_rst_n,
  output logic       rst_done,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STABLE   = 3'd1,
    ST_PHY_RST  = 3'd2,
    ST_PHY_WAIT = 3'd3,
    ST_RUN      = 3'd4
  } state_e;

  // Last counter value of each timed phase; the phase ends on this count.
  localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             locked_s;
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             phy_rst_n_q, phy_rst_n_d;
  logic             eth_rst_n_q, eth_rst_n_d;
  logic             rst_done_q,  rst_done_d;
  logic [7:0]       llc_q,       llc_d;

  assign locked_s = sync2_q;

  // Two-flop synchroniser bringing the asynchronous lock flag into clk_in.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= clk_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and phase counter; lock loss outranks every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_ZERO;
    case (state_q)
      ST_IDLE: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_PHY_RST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PHY_RST: begin
        if (!locked_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == PHY_RST_LAST) begin
          state_d = ST_PHY_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PHY_WAIT: begin
        if (!locked_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == PHY_WAIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_IDLE;
        end else if (sw_rst_req) begin
          state_d = ST_PHY_RST;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so outputs flip on the same edge as the state.
  always_comb begin
    phy_rst_n_d = 1'b0;
    eth_rst_n_d = 1'b0;
    rst_done_d  = 1'b0;
    case (state_d)
      ST_PHY_WAIT: begin
        phy_rst_n_d = 1'b1;
      end
      ST_RUN: begin
        phy_rst_n_d = 1'b1;
        eth_rst_n_d = 1'b1;
        rst_done_d  = 1'b1;
      end
      default: begin
        phy_rst_n_d = 1'b0;
      end
    endcase
  end

  // Saturating count of lock losses that knock the sequencer out of RUN.
  always_comb begin
    llc_d = llc_q;
    if ((state_q == ST_RUN) && !locked_s && (llc_q != 8'hFF)) begin
      llc_d = llc_q + 8'd1;
    end else begin
      llc_d = llc_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      phy_rst_n_q <= 1'b0;
      eth_rst_n_q <= 1'b0;
      rst_done_q  <= 1'b0;
      llc_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phy_rst_n_q <= phy_rst_n_d;
      eth_rst_n_q <= eth_rst_n_d;
      rst_done_q  <= rst_done_d;
      llc_q       <= llc_d;
    end
  end

  assign phy_rst_n     = phy_rst_n_q;
  assign eth_rst_n     = eth_rst_n_q;
  assign rst_done      = rst_done_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = llc_q;

endmodule
